// File: rtl/vector_logger.sv
// Capture/check engine: logs {stim, expected, resp} per sampled vector into a small circular
// buffer, counts vectors and mismatches, then drains the log in write order over a valid/ready
// read port so a host can dump it.
module vector_logger #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 1,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      sample_en,
  input  logic [IN_W-1:0]           stim,
  input  logic [OUT_W-1:0]          expected,
  input  logic [OUT_W-1:0]          resp,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [IN_W+2*OUT_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      done,
  output logic [CNT_W-1:0]          vectors,
  output logic [CNT_W-1:0]          errors
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = IN_W + 2 * OUT_W;

  localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CountLast = (PTR_W + 1)'(DEPTH - 1);
  localparam logic [PTR_W:0] CountOne  = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StDone
  } state_e;

  state_e           state_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             done_q;
  logic [CNT_W-1:0] vectors_q;
  logic [CNT_W-1:0] errors_q;

  // Log storage is not reset: a reset only has to discard the contents, which clearing the
  // pointers and count already does.
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic wr_en;
  logic rd_en;
  logic mismatch;

  // Write/read qualifiers; writes only happen in capture, reads only in drain, so they never
  // coincide.
  always_comb begin
    wr_en    = (state_q == StCapture) && sample_en;
    rd_valid = (state_q == StDrain) && (count_q != '0);
    rd_en    = rd_valid && rd_ready;
    mismatch = (resp != expected);
  end

  // Read port and status outputs; rd_data is forced to zero when nothing is presented.
  always_comb begin
    rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
    full    = (count_q == CountFull);
    count   = count_q;
    done    = done_q;
    vectors = vectors_q;
    errors  = errors_q;
  end

  // Control FSM together with pointers, occupancy and the saturating counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      vectors_q <= '0;
      errors_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            state_q   <= StCapture;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            vectors_q <= '0;
            errors_q  <= '0;
          end
        end

        StCapture: begin
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q  <= count_q + 1'b1;
            if (vectors_q != '1) begin
              vectors_q <= vectors_q + 1'b1;
            end
            if (mismatch && (errors_q != '1)) begin
              errors_q <= errors_q + 1'b1;
            end
          end
          // A sample arriving with stop is still logged, so only an empty, sample-free stop
          // skips the drain phase.
          if (wr_en && (count_q == CountLast)) begin
            state_q <= StDrain;
          end else if (stop) begin
            if (!wr_en && (count_q == '0)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end
        end

        StDrain: begin
          if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
            if (count_q == CountOne) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Log write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {stim, expected, resp};
    end
  end

  // Occupancy can never exceed the buffer size.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (count_q <= CountFull)
        else $error("vector_logger: count exceeded DEPTH");
    end
  end

endmodule
